// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary datapath: 2-bit trit codes,
// code-to-digit helpers and the word decoder state type.
package ternary_pkg;

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_ONE  = 2'b01;
  localparam logic [1:0] TRIT_TWO  = 2'b10;
  localparam logic [1:0] TRIT_INV  = 2'b11;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } dec_state_t;

  // The invalid code contributes nothing to the value; it is flagged separately.
  function automatic logic [1:0] trit_to_digit(input logic [1:0] code);
    logic [1:0] digit;
    case (code)
      TRIT_ONE: digit = 2'd1;
      TRIT_TWO: digit = 2'd2;
      default:  digit = 2'd0;
    endcase
    return digit;
  endfunction

  function automatic logic trit_is_invalid(input logic [1:0] code);
    return code == TRIT_INV;
  endfunction

endpackage

// File: rtl/ternary_horner_step.sv
// One Horner step of the ternary-to-binary conversion: acc_out = acc_in*3 + digit.
module ternary_horner_step
  import ternary_pkg::*;
#(
  parameter int BIN_W = 13
) (
  input  logic [BIN_W-1:0] acc_in,
  input  logic [1:0]       trit,
  output logic [BIN_W-1:0] acc_out,
  output logic             inv
);

  always_comb begin
    acc_out = (acc_in << 1) + acc_in + BIN_W'(trit_to_digit(trit));
    inv     = trit_is_invalid(trit);
  end

endmodule

// File: rtl/ternary_word_decoder.sv
// Serial ternary word reader: accumulates NTRITS trits MSB first and
// presents the binary value plus an invalid-code flag on a valid/ready port.
module ternary_word_decoder
  import ternary_pkg::*;
#(
  parameter int NTRITS = 8,
  parameter int BIN_W  = 13,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [1:0]       trit_in,
  input  logic             trit_valid,
  output logic             trit_ready,
  output logic [BIN_W-1:0] bin_out,
  output logic             bin_err,
  output logic             bin_valid,
  input  logic             bin_ready
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NTRITS - 1);

  dec_state_t       state_q, state_d;
  logic [BIN_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_sticky_q, err_sticky_d;
  logic [BIN_W-1:0] bin_out_q, bin_out_d;
  logic             bin_err_q, bin_err_d;
  logic             bin_valid_q, bin_valid_d;
  logic             trit_ready_q, trit_ready_d;

  logic [1:0]       step_trit;
  logic [BIN_W-1:0] step_acc;
  logic             step_inv;

  // Idle trit lines are forced to a known code so garbage never reaches the adder.
  assign step_trit = trit_valid ? trit_in : TRIT_ZERO;

  ternary_horner_step #(
    .BIN_W (BIN_W)
  ) u_step (
    .acc_in  (acc_q),
    .trit    (step_trit),
    .acc_out (step_acc),
    .inv     (step_inv)
  );

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    err_sticky_d = err_sticky_q;
    bin_out_d    = bin_out_q;
    bin_err_d    = bin_err_q;
    bin_valid_d  = bin_valid_q;
    trit_ready_d = trit_ready_q;

    if (flush) begin
      state_d      = ACCUM;
      acc_d        = '0;
      cnt_d        = '0;
      err_sticky_d = 1'b0;
      bin_valid_d  = 1'b0;
      trit_ready_d = 1'b1;
    end else begin
      case (state_q)
        ACCUM: begin
          if (trit_valid) begin
            if (cnt_q == LAST_CNT) begin
              bin_out_d    = step_acc;
              bin_err_d    = err_sticky_q | step_inv;
              state_d      = HOLD;
              acc_d        = '0;
              cnt_d        = '0;
              err_sticky_d = 1'b0;
              bin_valid_d  = 1'b1;
              trit_ready_d = 1'b0;
            end else begin
              acc_d        = step_acc;
              cnt_d        = cnt_q + CNT_W'(1);
              err_sticky_d = err_sticky_q | step_inv;
            end
          end
        end
        HOLD: begin
          if (bin_ready) begin
            state_d      = ACCUM;
            bin_valid_d  = 1'b0;
            trit_ready_d = 1'b1;
          end
        end
        default: begin
          state_d      = ACCUM;
          bin_valid_d  = 1'b0;
          trit_ready_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACCUM;
      acc_q        <= '0;
      cnt_q        <= '0;
      err_sticky_q <= 1'b0;
      bin_out_q    <= '0;
      bin_err_q    <= 1'b0;
      bin_valid_q  <= 1'b0;
      trit_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      err_sticky_q <= err_sticky_d;
      bin_out_q    <= bin_out_d;
      bin_err_q    <= bin_err_d;
      bin_valid_q  <= bin_valid_d;
      trit_ready_q <= trit_ready_d;
    end
  end

  assign trit_ready = trit_ready_q;
  assign bin_valid  = bin_valid_q;
  assign bin_out    = bin_out_q;
  assign bin_err    = bin_err_q;

endmodule

// File: tb/tb_ternary_word_decoder.sv
// Self-checking bench for ternary_word_decoder: directed vector table,
// abort/hold sequences and randomized words against a positional-value model.
module tb_ternary_word_decoder;

  localparam int NTRITS = 8;
  localparam int BIN_W  = 13;
  localparam int CNT_W  = 4;
  localparam int TMO    = 50;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [1:0]       trit_in;
  logic             trit_valid;
  logic             trit_ready;
  logic [BIN_W-1:0] bin_out;
  logic             bin_err;
  logic             bin_valid;
  logic             bin_ready;

  int n_cmp = 0;
  int n_bad = 0;

  ternary_word_decoder #(
    .NTRITS (NTRITS),
    .BIN_W  (BIN_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .trit_in    (trit_in),
    .trit_valid (trit_valid),
    .trit_ready (trit_ready),
    .bin_out    (bin_out),
    .bin_err    (bin_err),
    .bin_valid  (bin_valid),
    .bin_ready  (bin_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    int          gap;
    int          exp_val;
    bit          exp_err;
    string       name;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: value is the positional sum of digits times powers of three.
  function automatic void model(input logic [15:0] w, output int val, output bit err);
    int pw;
    int code;
    val = 0;
    err = 1'b0;
    pw  = 1;
    for (int i = 0; i < NTRITS; i++) begin
      code = int'((w >> (2 * i)) & 16'h3);
      if (code == 3) err = 1'b1;
      else val += code * pw;
      pw *= 3;
    end
  endfunction

  // Sends the first n trits of w, MSB first, with up to maxgap idle cycles before each.
  task automatic send_trits(input logic [15:0] w, input int n, input int maxgap);
    int t;
    for (int i = 0; i < n; i++) begin
      if (maxgap > 0) begin
        trit_valid = 1'b0;
        trit_in    = 2'($urandom);
        repeat ($urandom_range(0, maxgap)) @(negedge clk);
      end
      trit_valid = 1'b1;
      trit_in    = w[15 - 2 * i -: 2];
      t = 0;
      while (!trit_ready && t < TMO) begin
        @(negedge clk);
        t++;
      end
      if (t >= TMO) chk("trit_ready_timeout", 0, 1);
      @(negedge clk);
    end
    trit_valid = 1'b0;
    trit_in    = 2'($urandom);
  endtask

  task automatic send_word(input logic [15:0] w, input int maxgap, input string name);
    send_trits(w, NTRITS, maxgap);
    chk({name, "_valid_latency"}, int'(bin_valid), 1);
    chk({name, "_ready_low"}, int'(trit_ready), 0);
  endtask

  task automatic take_result(input int exp_val, input bit exp_err, input int hold,
                             input bit offer, input string name);
    int t;
    logic [BIN_W-1:0] held;
    t = 0;
    while (!bin_valid && t < TMO) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_valid_wait"}, int'(bin_valid), 1);
    chk({name, "_bin_out"}, int'(bin_out), exp_val);
    chk({name, "_bin_err"}, int'(bin_err), int'(exp_err));
    $display("word %s: bin_out=%0d bin_err=%0d (expect %0d/%0d)",
             name, bin_out, bin_err, exp_val, exp_err);
    held = bin_out;
    for (int k = 0; k < hold; k++) begin
      if (offer) begin
        trit_valid = 1'b1;
        trit_in    = 2'b10;
      end
      @(negedge clk);
      chk({name, "_hold_out"}, int'(bin_out), int'(held));
      chk({name, "_hold_err"}, int'(bin_err), int'(exp_err));
      chk({name, "_hold_valid"}, int'(bin_valid), 1);
      chk({name, "_hold_tready"}, int'(trit_ready), 0);
    end
    trit_valid = 1'b0;
    bin_ready  = 1'b1;
    @(negedge clk);
    bin_ready = 1'b0;
    chk({name, "_valid_drop"}, int'(bin_valid), 0);
    chk({name, "_tready_back"}, int'(trit_ready), 1);
  endtask

  vec_t vecs[6];

  initial begin
    int   val;
    bit   err;
    logic [15:0] w;

    vecs[0] = '{16'h0006, 0, 5,    1'b0, "five"};
    vecs[1] = '{16'hAAAA, 0, 6560, 1'b0, "all_two"};
    vecs[2] = '{16'h0000, 0, 0,    1'b0, "all_zero"};
    vecs[3] = '{16'h7000, 0, 2187, 1'b1, "inv_word"};
    vecs[4] = '{16'h5555, 0, 3280, 1'b0, "clean_after_inv"};
    vecs[5] = '{16'h0006, 3, 5,    1'b0, "five_gapped"};

    rst_n      = 1'b0;
    flush      = 1'b0;
    trit_in    = 2'b00;
    trit_valid = 1'b0;
    bin_ready  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_bin_valid", int'(bin_valid), 0);
    chk("rst_bin_out", int'(bin_out), 0);
    chk("rst_bin_err", int'(bin_err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_trit_ready", int'(trit_ready), 1);

    for (int i = 0; i < 6; i++) begin
      send_word(vecs[i].word, vecs[i].gap, vecs[i].name);
      take_result(vecs[i].exp_val, vecs[i].exp_err, 0, 1'b0, vecs[i].name);
    end

    // Consumer stalls for five cycles while trits are offered; none may be taken.
    send_word(16'h0006, 0, "stall");
    take_result(5, 1'b0, 5, 1'b1, "stall");
    send_word(16'h0001, 0, "after_stall");
    take_result(1, 1'b0, 0, 1'b0, "after_stall");

    // Asynchronous reset after four trits.
    send_trits(16'hAAAA, 4, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", int'(bin_valid), 0);
    chk("rst_mid_tready", int'(trit_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_word(16'h0006, 0, "after_rst");
    take_result(5, 1'b0, 0, 1'b0, "after_rst");

    // Asynchronous reset while a result is held.
    send_word(16'hAAAA, 0, "rst_hold");
    rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", int'(bin_valid), 0);
    chk("rst_hold_out", int'(bin_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Flush after three trits, with a coincident trit that must be dropped.
    send_trits(16'hAAAA, 3, 0);
    flush      = 1'b1;
    trit_valid = 1'b1;
    trit_in    = 2'b10;
    @(negedge clk);
    flush      = 1'b0;
    trit_valid = 1'b0;
    chk("flush_mid_valid", int'(bin_valid), 0);
    chk("flush_mid_tready", int'(trit_ready), 1);
    send_word(16'h0006, 0, "after_flush");
    take_result(5, 1'b0, 0, 1'b0, "after_flush");

    // Flush during HOLD beats a coincident bin_ready; the result is dropped.
    send_word(16'h7000, 0, "flush_hold");
    flush     = 1'b1;
    bin_ready = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    bin_ready = 1'b0;
    chk("flush_hold_valid", int'(bin_valid), 0);
    chk("flush_hold_tready", int'(trit_ready), 1);
    send_word(16'h5555, 0, "after_flush_hold");
    take_result(3280, 1'b0, 0, 1'b0, "after_flush_hold");

    // Randomized words, gaps and consumer stalls.
    for (int n = 0; n < 40; n++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        for (int i = 0; i < NTRITS; i++)
          if (w[2 * i +: 2] == 2'b11) w[2 * i +: 2] = 2'($urandom_range(0, 2));
      end
      model(w, val, err);
      send_word(w, $urandom_range(0, 3), $sformatf("rnd%0d", n));
      take_result(val, err, $urandom_range(0, 2), 1'($urandom), $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
